rr_decode_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream resource between `N` requesters.
- Keeps the winner as a registered binary index and drives the resource select lines from it through an internal binary-to-one-hot decode, so the one-hot grant and the index are always consistent.
- Sits between the requesting units and the decoder-selected resource.
- An optional hold timeout stops one requester from monopolising the resource.

---
 rtl/rr_decode_arbiter.sv | 149 ++++++++++++++
 tb/tb_rr_decode_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter: round-robin arbiter for N requesters sharing one
// decoder-selected resource. The winner is kept as a registered binary index.
// The one-hot grant is the decode of that index, so the two always agree.
//
// Optional feature: define RR_DECODE_ARBITER_TIMEOUT_EN to add a hold counter.
// It revokes a grant after MAX_HOLD cycles and pulses `timeout` for one cycle.
// Without the macro a grant lasts until release and `timeout` is tied to 0.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req        [N]     level request per requester
//   gnt        [N]     one-hot grant (registered), zero when idle
//   gnt_idx    [IDX_W] binary index of current/last winner (registered)
//   gnt_valid          high whenever gnt is non-zero (registered)
//   timeout            one-cycle pulse after a timeout revoke (registered)
module rr_decode_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned IDX_W    = $clog2(N),
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Elaboration-time parameter sanity checks
    if (N < 2 || (N & (N - 1)) != 0 || IDX_W != $clog2(N)) begin : g_bad_n
        $error("rr_decode_arbiter: N must be a power of two >= 2 with IDX_W = clog2(N)");
    end
    if (MAX_HOLD < 2) begin : g_bad_hold
        $error("rr_decode_arbiter: MAX_HOLD must be >= 2");
    end

    state_t           state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [IDX_W-1:0] gnt_idx_n;
    logic [N-1:0]     gnt_n;
    logic             gnt_valid_n;
    logic [IDX_W-1:0] win;

`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold, hold_n;
    logic              timeout_n;
`endif

    // Winner: first set request searching upward from ptr+1, wrapping mod N
    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        win   = ptr;
        found = 1'b0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = ptr + IDX_W'(i);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    // Next-state and registered-output values
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        gnt_idx_n = gnt_idx;
`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
        hold_n    = hold;
        timeout_n = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (|req) begin
                    state_n   = GRANT;
                    gnt_idx_n = win;
`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
                    hold_n    = '0;
`endif
                end
            end
            GRANT: begin
                // Release wins over a timeout on the same edge
                if (!req[gnt_idx]) begin
                    state_n = IDLE;
                    ptr_n   = gnt_idx;
                end
`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
                else if (hold == HOLD_LAST) begin
                    state_n   = IDLE;
                    ptr_n     = gnt_idx;
                    timeout_n = 1'b1;
                end else begin
                    hold_n = hold + HOLD_W'(1);
                end
`endif
            end
            default: state_n = IDLE;
        endcase

        // Select lines are the decode of the next index
        gnt_valid_n = (state_n == GRANT);
        gnt_n       = gnt_valid_n ? (N'(1) << gnt_idx_n) : '0;
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= IDX_W'(N - 1);
            gnt_idx   <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            gnt_idx   <= gnt_idx_n;
            gnt       <= gnt_n;
            gnt_valid <= gnt_valid_n;
        end
    end

`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
    // Hold counter and timeout pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold    <= '0;
            timeout <= 1'b0;
        end else begin
            hold    <= hold_n;
            timeout <= timeout_n;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// tb_rr_decode_arbiter: directed table-driven bench for rr_decode_arbiter
// (N=4, MAX_HOLD=8) plus hand-written multi-cycle sequences.
module tb_rr_decode_arbiter;

    localparam int unsigned N        = 4;
    localparam int unsigned IDX_W    = 2;
    localparam int unsigned MAX_HOLD = 8;
    localparam int unsigned NVEC     = 27;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             timeout;

    int total;
    int bad;

    typedef struct {
        logic             rst;
        logic [N-1:0]     req;
        logic [N-1:0]     gnt;
        logic [IDX_W-1:0] idx;
        logic             valid;
    } vec_t;

    vec_t vecs [NVEC];

    rr_decode_arbiter #(
        .N        (N),
        .IDX_W    (IDX_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N-1:0] eg,
                         input logic [IDX_W-1:0] ei, input logic ev, input logic et);
        total += 4;
        if (gnt !== eg) begin
            bad++;
            $display("FAIL %s gnt: got %b want %b", name, gnt, eg);
        end
        if (gnt_idx !== ei) begin
            bad++;
            $display("FAIL %s gnt_idx: got %0d want %0d", name, gnt_idx, ei);
        end
        if (gnt_valid !== ev) begin
            bad++;
            $display("FAIL %s gnt_valid: got %b want %b", name, gnt_valid, ev);
        end
        if (timeout !== et) begin
            bad++;
            $display("FAIL %s timeout: got %b want %b", name, timeout, et);
        end
    endtask

    // Drive req, take one edge, sample 1 time unit later
    task automatic step(input logic [N-1:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req   = '0;

        // rst, req, expected gnt, idx, valid
        vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0}; // held in reset
        vecs[1]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};
        vecs[2]  = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1}; // req 0 first after reset
        vecs[3]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0}; // release, ptr=0
        vecs[4]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1}; // single requester
        vecs[5]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
        vecs[6]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
        vecs[7]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
        vecs[8]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
        vecs[9]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
        vecs[10] = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0}; // drop, idx holds
        vecs[11] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1}; // park ptr at 3
        vecs[12] = '{1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0};
        vecs[13] = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1}; // round robin: 0
        vecs[14] = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1};
        vecs[15] = '{1'b0, 4'b1110, 4'b0000, 2'd0, 1'b0}; // dead cycle
        vecs[16] = '{1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1}; // 1
        vecs[17] = '{1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1};
        vecs[18] = '{1'b0, 4'b1101, 4'b0000, 2'd1, 1'b0};
        vecs[19] = '{1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1}; // 2
        vecs[20] = '{1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1};
        vecs[21] = '{1'b0, 4'b1011, 4'b0000, 2'd2, 1'b0};
        vecs[22] = '{1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1}; // 3
        vecs[23] = '{1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1};
        vecs[24] = '{1'b0, 4'b0111, 4'b0000, 2'd3, 1'b0};
        vecs[25] = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1}; // wraps to 0
        vecs[26] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0}; // ptr=0

        for (int i = 0; i < int'(NVEC); i++) begin
            rst = vecs[i].rst;
            step(vecs[i].req);
            check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].idx, vecs[i].valid, 1'b0);
        end

        // Mid-grant asynchronous reset, then search restarts at 0
        step(4'b0100);
        check("mid_rst_pre", 4'b0100, 2'd2, 1'b1, 1'b0);
        #1 rst = 1'b1;
        #1 check("mid_rst_async", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(4'b1100);
        check("mid_rst_after", 4'b0100, 2'd2, 1'b1, 1'b0);
        step(4'b0000);
        check("mid_rst_rel", 4'b0000, 2'd2, 1'b0, 1'b0);
        // ptr is now 2

`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
        // Timeout: requester 0 held for exactly MAX_HOLD cycles
        for (int c = 0; c < int'(MAX_HOLD); c++) begin
            step(4'b0011);
            check($sformatf("to_hold%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        step(4'b0011);
        check("to_revoke", 4'b0000, 2'd0, 1'b0, 1'b1);
        step(4'b0011);
        check("to_next", 4'b0010, 2'd1, 1'b1, 1'b0);
        // Release on the cycle the counter saturates: no timeout
        for (int c = 1; c < int'(MAX_HOLD); c++) begin
            step(4'b0011);
            check($sformatf("sim_hold%0d", c), 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        step(4'b0001);
        check("sim_release", 4'b0000, 2'd1, 1'b0, 1'b0);
        // ptr advanced to 1, so 0 wins over 1
        step(4'b0011);
        check("sim_ptr", 4'b0001, 2'd0, 1'b1, 1'b0);
        step(4'b0000);
        check("sim_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
`else
        // Without timeout a grant lasts well past MAX_HOLD
        for (int c = 0; c < int'(MAX_HOLD) + 4; c++) begin
            step(4'b0011);
            check($sformatf("long_hold%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        step(4'b0010);
        check("long_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
        step(4'b0011);
        check("long_next", 4'b0010, 2'd1, 1'b1, 1'b0);
        step(4'b0000);
        check("long_idle", 4'b0000, 2'd1, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
